// File: rtl/cpu_trap_unit_pkg.sv
// Shared CSR addresses, bit positions, mcause codes and decoder exception codes
// for the machine-mode trap unit.
package cpu_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_TIMER    = 7;
    localparam int IRQ_EXT      = 11;

    localparam logic [31:0] MCAUSE_IRQ_EXT    = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_IRQ_TIMER  = 32'h8000_0007;
    localparam logic [31:0] MCAUSE_ECALL      = 32'd11;
    localparam logic [31:0] MCAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] MCAUSE_ILLEGAL    = 32'd2;

    // Exception codes as produced by the instruction decoder.
    typedef enum logic [1:0] {
        EXC_ECALL         = 2'd0,
        EXC_BREAKPOINT    = 2'd1,
        EXC_ILLEGAL_INSTR = 2'd2
    } exc_cause_t;

    // The unused decoder code is treated as an illegal instruction.
    function automatic logic [31:0] exc_mcause(input logic [1:0] code);
        case (code)
            EXC_ECALL:      return MCAUSE_ECALL;
            EXC_BREAKPOINT: return MCAUSE_BREAKPOINT;
            default:        return MCAUSE_ILLEGAL;
        endcase
    endfunction

    function automatic logic [31:0] exc_mtval(input logic [1:0] code,
                                              input logic [31:0] pc,
                                              input logic [31:0] instr);
        case (code)
            EXC_ECALL:      return 32'd0;
            EXC_BREAKPOINT: return pc;
            default:        return instr;
        endcase
    endfunction

endpackage

// File: rtl/cpu_trap_csrs.sv
// Machine-mode trap CSR storage and the combinational CSR read mux.
// Trap and mret side effects arrive pre-qualified from the trap FSM.
module cpu_trap_csrs
    import cpu_trap_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_we,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        trap_take,
    input  logic [31:0] trap_mcause,
    input  logic [31:0] trap_mepc,
    input  logic [31:0] trap_mtval,
    input  logic        mret_take,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        status_mie,
    output logic        irq_meie,
    output logic        irq_mtie,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    logic        status_mpie;
    logic [31:0] mcause;
    logic [31:0] mtval;

    // NOTE: async reset of architectural state is fine here because these are plain
    // flops, not an inferred memory; non-blocking assignments keep the trap update
    // (written last) winning over a same-cycle CSR write to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            irq_meie    <= 1'b0;
            irq_mtie    <= 1'b0;
            mtvec       <= RESET_MTVEC & ~32'h0000_0002;
            mepc        <= 32'd0;
            mcause      <= 32'd0;
            mtval       <= 32'd0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        status_mie  <= csr_wdata[MSTATUS_MIE];
                        status_mpie <= csr_wdata[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        irq_meie <= csr_wdata[IRQ_EXT];
                        irq_mtie <= csr_wdata[IRQ_TIMER];
                    end
                    CSR_MTVEC:  mtvec  <= csr_wdata & ~32'h0000_0002;
                    CSR_MEPC:   mepc   <= {csr_wdata[31:2], 2'b00};
                    CSR_MCAUSE: mcause <= csr_wdata;
                    CSR_MTVAL:  mtval  <= csr_wdata;
                    default: ;
                endcase
            end
            if (trap_take) begin
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
                mepc        <= {trap_mepc[31:2], 2'b00};
                mcause      <= trap_mcause;
                mtval       <= trap_mtval;
            end else if (mret_take) begin
                status_mie  <= status_mpie;
                status_mpie <= 1'b1;
            end
        end
    end

    // NOTE: every output of this combinational block gets a default first so no latch is inferred.
    always_comb begin
        csr_rdata   = 32'd0;
        csr_illegal = 1'b0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[12:11]          = 2'b11;
                csr_rdata[MSTATUS_MPIE]   = status_mpie;
                csr_rdata[MSTATUS_MIE]    = status_mie;
            end
            CSR_MIE: begin
                csr_rdata[IRQ_EXT]   = irq_meie;
                csr_rdata[IRQ_TIMER] = irq_mtie;
            end
            CSR_MIP: begin
                csr_rdata[IRQ_EXT]   = irq_ext;
                csr_rdata[IRQ_TIMER] = irq_timer;
            end
            CSR_MTVEC:  csr_rdata = mtvec;
            CSR_MEPC:   csr_rdata = mepc;
            CSR_MCAUSE: csr_rdata = mcause;
            CSR_MTVAL:  csr_rdata = mtval;
            default:    csr_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_trap_unit.sv
// Machine-mode trap unit: picks one of interrupt / exception / mret at commit,
// kills the trapping instruction and holds a redirect until the fetch side accepts it.
module cpu_trap_unit
    import cpu_trap_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        exception,
    input  logic [1:0]  exception_cause,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic [11:0] csr_addr,
    input  logic        csr_write,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        commit_kill,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        stall
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;

    logic [0:0]  state;
    logic        status_mie, irq_meie, irq_mtie;
    logic [31:0] mtvec, mepc;
    logic        evaluate, ext_pending, timer_pending, irq_pending;
    logic        take_irq, take_exc, take_mret, take_trap;
    logic [31:0] trap_mcause, trap_mtval, trap_target;
    logic        csr_we;

    // rst is folded in so commit_kill stays low while reset is held.
    assign evaluate      = (state == ST_IDLE) && instr_valid && !rst;
    assign ext_pending   = irq_ext & irq_meie;
    assign timer_pending = irq_timer & irq_mtie;
    assign irq_pending   = status_mie & (ext_pending | timer_pending);

    assign take_irq  = evaluate && irq_pending;
    assign take_exc  = evaluate && !irq_pending && exception;
    assign take_mret = evaluate && !irq_pending && !exception && mret;
    assign take_trap = take_irq || take_exc;

    assign commit_kill = take_trap;
    assign csr_we      = csr_write && instr_valid && !commit_kill && (state == ST_IDLE);

    always_comb begin
        trap_mcause = exc_mcause(exception_cause);
        trap_mtval  = exc_mtval(exception_cause, pc, instr);
        if (take_irq) begin
            trap_mcause = ext_pending ? MCAUSE_IRQ_EXT : MCAUSE_IRQ_TIMER;
            trap_mtval  = 32'd0;
        end
        trap_target = {mtvec[31:2], 2'b00};
        if (take_irq && mtvec[0])
            trap_target = trap_target + {26'd0, trap_mcause[3:0], 2'b00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            redirect_pc <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_trap) begin
                        state       <= ST_REDIRECT;
                        redirect_pc <= trap_target;
                    end else if (take_mret) begin
                        state       <= ST_REDIRECT;
                        redirect_pc <= mepc;
                    end
                end
                default: begin
                    if (redirect_ready)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    assign redirect_valid = (state == ST_REDIRECT);
    assign stall          = (state == ST_REDIRECT);

    cpu_trap_csrs #(
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csrs (
        .clk         (clk),
        .rst         (rst),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_we      (csr_we),
        .irq_ext     (irq_ext),
        .irq_timer   (irq_timer),
        .trap_take   (take_trap),
        .trap_mcause (trap_mcause),
        .trap_mepc   (pc),
        .trap_mtval  (trap_mtval),
        .mret_take   (take_mret),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .status_mie  (status_mie),
        .irq_meie    (irq_meie),
        .irq_mtie    (irq_mtie),
        .mtvec       (mtvec),
        .mepc        (mepc)
    );

endmodule
